// File: rtl/alu_pipe_if.sv
// alu_pipe_if: command/result bundle for alu_pipe.
//   in_valid/in_ready       command handshake (opcode, acc_sel, A, B)
//   out_valid/out_ready     result handshake (C, ovf)
//   op_cnt                  running count of completed result handshakes
// Modports: slave = the ALU itself, master = command source / result consumer.
interface alu_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       opcode;
  logic             acc_sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   C;
  logic             ovf;
  logic [CNT_W-1:0] op_cnt;

  modport slave (
    input  in_valid, opcode, acc_sel, A, B, out_ready,
    output in_ready, out_valid, C, ovf, op_cnt
  );

  modport master (
    output in_valid, opcode, acc_sel, A, B, out_ready,
    input  in_ready, out_valid, C, ovf, op_cnt
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU (ADD/SUB/XOR/OR) with optional
// accumulation into a running result register.
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   alu_pipe_if.slave: command handshake in, result handshake out,
//         completed-operation counter
// Stage S1 holds the accepted command; stage S2 holds the result. The
// accumulator is rewritten on every S2 load, so back-to-back accumulate
// commands always see the immediately preceding result without stalling.
module alu_pipe #(
  parameter int WIDTH  = 4,
  parameter int SAT_EN = 0,
  parameter int CNT_W  = 8
) (
  input logic         clk,
  input logic         rst,
  alu_pipe_if.slave   bus
);
  localparam int RW = WIDTH + 1;
  localparam int EW = WIDTH + 2;
  localparam logic [RW-1:0] SAT_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [RW-1:0] SAT_MIN = {1'b1, {WIDTH{1'b0}}};

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic             s1_acc;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             out_valid_q;
  logic [RW-1:0]    c_q;
  logic             ovf_q;
  logic [RW-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s1_adv;
  logic             in_hs;
  logic             out_hs;

  logic [RW-1:0]    x;
  logic [RW-1:0]    b_ext;
  logic [EW-1:0]    full;
  logic [RW-1:0]    res_c;
  logic             res_ovf;

  assign s1_adv       = s1_valid && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = rst && (!s1_valid || s1_adv);
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign out_hs       = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.C         = c_q;
  assign bus.ovf       = ovf_q;
  assign bus.op_cnt    = cnt_q;

  always_comb begin
    x       = s1_acc ? acc_q : {s1_a[WIDTH-1], s1_a};
    b_ext   = {s1_b[WIDTH-1], s1_b};
    full    = '0;
    res_c   = '0;
    res_ovf = 1'b0;
    case (s1_op)
      2'd0:    full = {x[RW-1], x} + {b_ext[RW-1], b_ext};
      2'd1:    full = {x[RW-1], x} - {b_ext[RW-1], b_ext};
      default: full = '0;
    endcase
    if (s1_op == 2'd2) begin
      res_c = x ^ b_ext;
    end else if (s1_op == 2'd3) begin
      res_c = x | b_ext;
    end else if (full[EW-1] != full[EW-2]) begin
      // Top two bits disagree: the sum does not fit in RW signed bits.
      res_ovf = 1'b1;
      if (SAT_EN != 0) begin
        res_c = full[EW-1] ? SAT_MIN : SAT_MAX;
      end else begin
        res_c = full[RW-1:0];
      end
    end else begin
      res_c = full[RW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid    <= 1'b0;
      s1_op       <= '0;
      s1_acc      <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (in_hs) begin
        s1_op  <= bus.opcode;
        s1_acc <= bus.acc_sel;
        s1_a   <= bus.A;
        s1_b   <= bus.B;
      end

      if (in_hs) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        c_q         <= res_c;
        ovf_q       <= res_ovf;
        out_valid_q <= 1'b1;
        acc_q       <= res_c;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end

      if (out_hs) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: drives one command stream into a saturating and a wrapping
// alu_pipe in parallel and checks both result streams against a scoreboard.
module tb_alu_pipe;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int HI = (1 << W) - 1;
  localparam int LO = -(1 << W);
  localparam int SPAN = 1 << (W + 1);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  logic clk = 1'b0;
  logic rst;

  alu_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus_s ();
  alu_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus_w ();

  alu_pipe #(.WIDTH(W), .SAT_EN(1), .CNT_W(CW)) dut_sat (.clk(clk), .rst(rst), .bus(bus_s));
  alu_pipe #(.WIDTH(W), .SAT_EN(0), .CNT_W(CW)) dut_wrap (.clk(clk), .rst(rst), .bus(bus_w));

  assign bus_w.in_valid  = bus_s.in_valid;
  assign bus_w.opcode    = bus_s.opcode;
  assign bus_w.acc_sel   = bus_s.acc_sel;
  assign bus_w.A         = bus_s.A;
  assign bus_w.B         = bus_s.B;
  assign bus_w.out_ready = bus_s.out_ready;

  always #5 clk = ~clk;

  typedef struct {
    int c_s; bit o_s;
    int c_w; bit o_w;
    int cyc; bit lat;
  } exp_t;

  typedef struct {
    logic [1:0] op; bit accs; int a; int b;
    int c_s; bit o_s; int c_w; bit o_w;
  } vec_t;

  exp_t q[$];
  vec_t tbl[16];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  hs_total = 0;
  int  hs_base = 0;
  int  acc_s = 0;
  int  acc_w = 0;
  bit  rnd_done = 1'b0;

  task automatic chk_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int cs, input bit os, input int cw, input bit ow, input bit lat);
    exp_t e;
    e.c_s = cs; e.o_s = os; e.c_w = cw; e.o_w = ow; e.cyc = 0; e.lat = lat;
    return e;
  endfunction

  function automatic int model(input logic [1:0] op, input int x, input int b, input bit sat, output bit o);
    int f;
    o = 1'b0;
    case (op)
      OP_ADD:  f = x + b;
      OP_SUB:  f = x - b;
      OP_XOR:  return x ^ b;
      default: return x | b;
    endcase
    if (f > HI) begin
      o = 1'b1;
      return sat ? HI : f - SPAN;
    end
    if (f < LO) begin
      o = 1'b1;
      return sat ? LO : f + SPAN;
    end
    return f;
  endfunction

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus_s.out_valid && bus_s.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: result C=%0d appeared, expected no pending result",
                   int'($signed(bus_s.C)));
        end else begin
          e = q.pop_front();
          chk_eq("c_sat", int'($signed(bus_s.C)), e.c_s);
          chk_eq("ovf_sat", int'(bus_s.ovf), int'(e.o_s));
          chk_eq("valid_wrap", int'(bus_w.out_valid), 1);
          chk_eq("c_wrap", int'($signed(bus_w.C)), e.c_w);
          chk_eq("ovf_wrap", int'(bus_w.ovf), int'(e.o_w));
          if (e.lat) chk_eq("latency", cyc - e.cyc, 2);
          hs_total++;
        end
      end
    end
  endtask

  task automatic send(input logic [1:0] op, input bit accs, input int a, input int b, input exp_t e);
    bus_s.opcode   = op;
    bus_s.acc_sel  = accs;
    bus_s.A        = W'(a);
    bus_s.B        = W'(b);
    bus_s.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus_s.in_ready) begin
        e.cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 64 cycles");
    bus_s.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus_s.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("in_ready_rst_sat", int'(bus_s.in_ready), 0);
    chk_eq("in_ready_rst_wrap", int'(bus_w.in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    hs_base = hs_total;
    acc_s = 0;
    acc_w = 0;
    @(negedge clk);
    chk_eq("out_valid_rst", int'(bus_s.out_valid), 0);
    chk_eq("out_valid_rst_wrap", int'(bus_w.out_valid), 0);
    chk_eq("op_cnt_rst", int'(bus_s.op_cnt), 0);
    chk_eq("c_rst", int'($signed(bus_s.C)), 0);
    chk_eq("ovf_rst", int'(bus_s.ovf), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus_s.in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("op_cnt_sat", int'(bus_s.op_cnt), (hs_total - hs_base) % (1 << CW));
    chk_eq("op_cnt_wrap", int'(bus_w.op_cnt), (hs_total - hs_base) % (1 << CW));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    rst             = 1'b0;
    bus_s.in_valid  = 1'b0;
    bus_s.opcode    = OP_ADD;
    bus_s.acc_sel   = 1'b0;
    bus_s.A         = '0;
    bus_s.B         = '0;
    bus_s.out_ready = 1'b1;

    //          op      acc a   b   c_sat ovf  c_wrap ovf
    tbl[0]  = '{OP_ADD, 0,  7,  7,  14,  0,  14,  0};
    tbl[1]  = '{OP_SUB, 0, -8,  7, -15,  0, -15,  0};
    tbl[2]  = '{OP_XOR, 0, -1,  5,  -6,  0,  -6,  0};
    tbl[3]  = '{OP_OR,  0,  4,  3,   7,  0,   7,  0};
    tbl[4]  = '{OP_ADD, 0,  0,  0,   0,  0,   0,  0};
    tbl[5]  = '{OP_ADD, 1,  0,  7,   7,  0,   7,  0};
    tbl[6]  = '{OP_ADD, 1,  0,  7,  14,  0,  14,  0};
    tbl[7]  = '{OP_ADD, 1,  0,  7,  15,  1, -11,  1};
    tbl[8]  = '{OP_SUB, 1,  0, -8,  15,  1,  -3,  0};
    tbl[9]  = '{OP_SUB, 1,  0,  7,   8,  0, -10,  0};
    tbl[10] = '{OP_ADD, 1,  0, -8,   0,  0,  14,  1};
    tbl[11] = '{OP_ADD, 0, -8, -8, -16,  0, -16,  0};
    tbl[12] = '{OP_SUB, 1,  0,  7, -16,  1,   9,  1};
    tbl[13] = '{OP_SUB, 0,  7, -8,  15,  0,  15,  0};
    tbl[14] = '{OP_XOR, 0, -8,  7,  -1,  0,  -1,  0};
    tbl[15] = '{OP_OR,  1,  0, -8,  -1,  0,  -1,  0};

    fork
      cycle_counter();
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed vectors, back to back with the consumer always ready.
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].op, tbl[i].accs, tbl[i].a, tbl[i].b,
           mk(tbl[i].c_s, tbl[i].o_s, tbl[i].c_w, tbl[i].o_w, 1'b1));
    end
    chk_eq("throughput_cycles", cyc - t0, 16);
    drain();

    // Backpressure: two ops fill the pipe, the third waits.
    do_reset();
    bus_s.out_ready = 1'b0;
    send(OP_ADD, 1'b0, 1, 2, mk(3, 0, 3, 0, 0));
    send(OP_SUB, 1'b0, 5, 1, mk(4, 0, 4, 0, 0));
    fork
      send(OP_XOR, 1'b0, 3, 5, mk(6, 0, 6, 0, 0));
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk_eq("bp_in_ready", int'(bus_s.in_ready), 0);
          chk_eq("bp_out_valid", int'(bus_s.out_valid), 1);
          chk_eq("bp_c_hold", int'($signed(bus_s.C)), 3);
          chk_eq("bp_c_hold_wrap", int'($signed(bus_w.C)), 3);
        end
        @(posedge clk);
        #1;
        bus_s.out_ready = 1'b1;
      end
    join
    drain();
    chk_eq("bp_op_cnt", int'(bus_s.op_cnt), 3);

    // Reset with both stages full; in-flight ops and ACC are discarded.
    bus_s.out_ready = 1'b0;
    send(OP_ADD, 1'b0, 1, 1, mk(2, 0, 2, 0, 0));
    send(OP_ADD, 1'b0, 2, 2, mk(4, 0, 4, 0, 0));
    do_reset();
    bus_s.out_ready = 1'b1;
    send(OP_ADD, 1'b1, 0, 3, mk(3, 0, 3, 0, 1));
    drain();

    // Randomised stream with random consumer stalls; long enough to wrap op_cnt.
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus_s.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int n = 0; n < 270; n++) begin
      logic [1:0] op;
      bit accs, os, ow;
      int a, b, cs, cw;
      op   = 2'($urandom_range(0, 3));
      accs = 1'($urandom_range(0, 1));
      a    = int'($urandom_range(0, 15)) - 8;
      b    = int'($urandom_range(0, 15)) - 8;
      cs   = model(op, accs ? acc_s : a, b, 1'b1, os);
      cw   = model(op, accs ? acc_w : a, b, 1'b0, ow);
      acc_s = cs;
      acc_w = cw;
      send(op, accs, a, b, mk(cs, os, cw, ow, 1'b0));
      if ($urandom_range(0, 4) == 0) begin
        bus_s.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rnd_done = 1'b1;
    @(posedge clk);
    #2;
    bus_s.out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the team's 4-bit combinational ALU.
- Accepts signed operand pairs over a valid/ready handshake and computes ADD/SUB/XOR/OR.
- Optionally accumulates into an internal running result, with selectable saturate or wrap on overflow.
- Sits between the stimulus/command source and the result consumer; tolerates backpressure on either side.

Parameters:
WIDTH, 4, signed operand width of A and B; result width is WIDTH+1
SAT_EN, 0, 1 = saturate accumulate overflow to the (WIDTH+1)-bit signed limits; 0 = wrap (truncate)
CNT_W, 8, width of completed-operation counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
in_valid  input  1  operation present on opcode/acc_sel/A/B
in_ready  output  1  block can accept an operation this cycle
opcode  input  2  0=ADD, 1=SUB, 2=XOR, 3=OR
acc_sel  input  1  1 = use accumulator in place of A
A  input  WIDTH  signed operand A
B  input  WIDTH  signed operand B
out_valid  output  1  result present on C/ovf
out_ready  input  1  consumer accepts result this cycle
C  output  WIDTH+1  signed result
ovf  output  1  result overflowed the (WIDTH+1)-bit range, saturated or wrapped
op_cnt  output  CNT_W  count of completed output handshakes

Behaviour:
- Reset: on a rising clk with rst=0, clear the following registers to 0: s1_valid, out_valid, C, ovf, op_cnt, accumulator ACC. in_ready=0 while rst=0.
- Stage S1 register: opcode, acc_sel, A, B, s1_valid.
  - Load S1 when in_valid && in_ready.
  - in_ready = rst && (!s1_valid || s1_adv).
- Stage S2 output register: C, ovf, out_valid.
  - s1_adv = s1_valid && (!out_valid || out_ready).
  - On s1_adv, compute the result, load C/ovf, set out_valid=1, and set ACC to the new C.
  - Otherwise, if out_valid && out_ready, clear out_valid.
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Sustained throughput is 1 op/cycle.
- Operand X: X = ACC when acc_sel=1; otherwise X = A sign-extended to WIDTH+1.
- Arithmetic: compute at WIDTH+2 bits. ADD: X+B; SUB: X−B (B sign-extended).
  - If the full result fits in WIDTH+1 bits, C = full result and ovf=0.
  - Otherwise ovf=1. With SAT_EN=1, C = +(2^WIDTH−1) on positive overflow, −2^WIDTH on negative overflow. With SAT_EN=0, C = low WIDTH+1 bits.
  - Non-accumulate ADD/SUB can never set ovf.
- Logic ops: XOR/OR are bitwise on X and sign-extended B; ovf=0.
- ACC update: ACC updates on every S2 load, accumulate or not. Back-to-back acc_sel ops therefore each see the immediately preceding result; no bubble or stall is needed.
- Backpressure: while out_valid && !out_ready, C/ovf hold stable. S1 can still fill, after which in_ready=0.
  - No result is dropped or duplicated; order is preserved.
- op_cnt: increments on each out_valid && out_ready; wraps from 2^CNT_W−1 to 0.
- Simultaneous in/out handshake in the same cycle, with S1 full: S1 advances and reloads in that cycle.
- Reset mid-operation: all in-flight ops are discarded, ACC=0, and out_valid drops on the reset edge.
- Inputs are sampled only on handshake; values while in_valid=0 are ignored.

Test Plan:
- WIDTH=4, out_ready=1: ADD A=7,B=7 accepted at cycle 0 -> out_valid at cycle 2, C=14, ovf=0. SUB A=−8,B=7 -> C=−15, ovf=0.
- Accumulate, SAT_EN=1: after reset, acc_sel=1 ADD B=7 three consecutive cycles -> C=7, 14, 15, with ovf=0,0,1. Then acc_sel=1 SUB B=−8 -> C=15 saturated, ovf=1.
- Accumulate, SAT_EN=0: same three ADDs -> C=7, 14, −11, with ovf=0,0,1.
- Logic ops: XOR A=−1,B=5 -> C=−6; OR A=4,B=3 -> C=7; ovf=0 on both.
- Backpressure: out_ready=0, offer 3 ops back to back -> in_ready=0 after 2 accepted. C holds the first result. Release out_ready -> all 3 results emerge in order, op_cnt=3.
- Reset mid-stream: rst=0 for one edge with both stages full -> out_valid=0, op_cnt=0. A following acc_sel ADD B=3 -> C=3.
